// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: register-file geometry and
// the per-cycle write-slot winner encoding.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_PIPE,
        WB_FIFO,
        WB_BYPASS
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Late-result queue. Each slot has a valid bit that can be cleared by address,
// so squashed entries still occupy space until they drain past the head.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [REG_ADDR_W-1:0]   push_addr,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    input  logic                    kill_en,
    input  logic [REG_ADDR_W-1:0]   kill_addr,
    output logic                    head_valid,
    output logic [REG_ADDR_W-1:0]   head_addr,
    output logic [WIDTH-1:0]        head_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  live_count,
    output logic [REG_COUNT-1:0]    pending_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                  valid_q [DEPTH];
    logic [REG_ADDR_W-1:0] addr_q  [DEPTH];
    logic [WIDTH-1:0]      data_q  [DEPTH];
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      occ_q;

    // Popped slots have their valid bit cleared, so an address kill may scan every slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            if (kill_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (addr_q[i] == kill_addr) begin
                        valid_q[i] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= push_addr;
                data_q[tail_q]  <= push_data;
                tail_q          <= tail_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_comb begin
        live_count   = '0;
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live_count = live_count + CNT_W'(valid_q[i]);
            if (valid_q[i]) begin
                pending_mask[addr_q[i]] = 1'b1;
            end
        end
    end

    assign head_valid = valid_q[head_q];
    assign head_addr  = addr_q[head_q];
    assign head_data  = data_q[head_q];
    assign empty      = (occ_q == '0);
    assign full       = (occ_q == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one register-file write per cycle, pipeline first, then
// queued late results, then a direct bypass of a late result into an empty queue.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int width = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pipe_valid,
    input  logic [REG_ADDR_W-1:0]   pipe_addr,
    input  logic [width-1:0]        pipe_data,
    input  logic                    late_valid,
    output logic                    late_ready,
    input  logic [REG_ADDR_W-1:0]   late_addr,
    input  logic [width-1:0]        late_data,
    output logic [REG_ADDR_W-1:0]   W_addr,
    output logic [width-1:0]        W_data,
    output logic                    wr_enable,
    output logic [REG_COUNT-1:0]    pending_mask,
    output logic [$clog2(DEPTH):0]  queue_count
);

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  head_valid;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [width-1:0]      head_data;
    logic                  pipe_win;
    logic                  late_xfer;
    logic                  late_live;
    wb_src_t               src;

    logic                  wr_enable_q;
    logic [REG_ADDR_W-1:0] W_addr_q;
    logic [width-1:0]      W_data_q;

    wb_fifo #(
        .WIDTH (width),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (fifo_push),
        .push_addr    (late_addr),
        .push_data    (late_data),
        .pop          (fifo_pop),
        .kill_en      (pipe_win),
        .kill_addr    (pipe_addr),
        .head_valid   (head_valid),
        .head_addr    (head_addr),
        .head_data    (head_data),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .live_count   (queue_count),
        .pending_mask (pending_mask)
    );

    assign late_ready = !fifo_full && reset;
    assign late_xfer  = late_valid && late_ready;
    assign late_live  = late_xfer && (late_addr != '0);
    assign pipe_win   = pipe_valid && (pipe_addr != '0);

    // A late result colliding with a winning pipeline write to the same register is older, so it is dropped.
    always_comb begin
        src = WB_NONE;
        if (pipe_win) begin
            src = WB_PIPE;
        end else if (!fifo_empty) begin
            src = WB_FIFO;
        end else if (late_live) begin
            src = WB_BYPASS;
        end
        fifo_pop  = (src == WB_FIFO);
        fifo_push = late_live && (src != WB_BYPASS)
                    && !(pipe_win && (late_addr == pipe_addr));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_enable_q <= 1'b0;
            W_addr_q    <= '0;
            W_data_q    <= '0;
        end else begin
            wr_enable_q <= 1'b0;
            unique case (src)
                WB_PIPE: begin
                    wr_enable_q <= 1'b1;
                    W_addr_q    <= pipe_addr;
                    W_data_q    <= pipe_data;
                end
                WB_FIFO: begin
                    if (head_valid) begin
                        wr_enable_q <= 1'b1;
                        W_addr_q    <= head_addr;
                        W_data_q    <= head_data;
                    end
                end
                WB_BYPASS: begin
                    wr_enable_q <= 1'b1;
                    W_addr_q    <= late_addr;
                    W_data_q    <= late_data;
                end
                default: begin
                end
            endcase
        end
    end

    assign wr_enable = wr_enable_q;
    assign W_addr    = W_addr_q;
    assign W_data    = W_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter; each scenario task carries its own expectations.
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        late_valid;
    logic        late_ready;
    logic [4:0]  late_addr;
    logic [31:0] late_data;
    logic [4:0]  W_addr;
    logic [31:0] W_data;
    logic        wr_enable;
    logic [31:0] pending_mask;
    logic [2:0]  queue_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] shadowRf [32];
    logic        saw11 = 1'b0;

    wb_arbiter #(.width(32), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_valid   (pipe_valid),
        .pipe_addr    (pipe_addr),
        .pipe_data    (pipe_data),
        .late_valid   (late_valid),
        .late_ready   (late_ready),
        .late_addr    (late_addr),
        .late_data    (late_data),
        .W_addr       (W_addr),
        .W_data       (W_data),
        .wr_enable    (wr_enable),
        .pending_mask (pending_mask),
        .queue_count  (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every register-file write so end-of-scenario contents can be checked.
    always @(negedge clk) begin
        if (reset && wr_enable) begin
            shadowRf[W_addr] = W_data;
            if (W_data == 32'h11) saw11 = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        pipe_valid = 1'b0; pipe_addr = '0; pipe_data = '0;
        late_valid = 1'b0; late_addr = '0; late_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr: got %b expected 0", wr_enable); end
        checks++; if (W_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_waddr: got %0d expected 0", W_addr); end
        checks++; if (W_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", W_data); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", queue_count); end
        checks++; if (pending_mask !== 32'd0) begin errors++; $display("[TB] FAIL reset_mask: got %h expected 0", pending_mask); end
        checks++; if (late_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", late_ready); end
        reset = 1'b1;
        #1;
        checks++; if (late_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b expected 1", late_ready); end
    endtask

    task automatic test_bypass();
        tick();
        late_valid = 1'b1; late_addr = 5'd5; late_data = 32'hDEADBEEF;
        checks++; if (late_ready !== 1'b1) begin errors++; $display("[TB] FAIL bypass_ready: got %b expected 1", late_ready); end
        tick();
        idleInputs();
        checks++; if (wr_enable !== 1'b1) begin errors++; $display("[TB] FAIL bypass_wr: got %b expected 1", wr_enable); end
        checks++; if (W_addr !== 5'd5) begin errors++; $display("[TB] FAIL bypass_waddr: got %0d expected 5", W_addr); end
        checks++; if (W_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL bypass_wdata: got %h expected deadbeef", W_data); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("[TB] FAIL bypass_count: got %0d expected 0", queue_count); end
        tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("[TB] FAIL bypass_idle_wr: got %b expected 0", wr_enable); end
        checks++; if (W_addr !== 5'd5) begin errors++; $display("[TB] FAIL bypass_hold_addr: got %0d expected 5", W_addr); end
    endtask

    task automatic test_fill_drain();
        int j = 0;
        logic [2:0] expCount [5] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        for (int k = 0; k < 8; k++) begin
            pipe_valid = 1'b1; pipe_addr = 5'(k + 1); pipe_data = 32'h100 + k;
            late_valid = 1'b1; late_addr = 5'(10 + j); late_data = 32'h500 + j;
            checks++; if (late_ready !== (k < 4)) begin errors++; $display("[TB] FAIL fill_ready[%0d]: got %b expected %b", k, late_ready, (k < 4)); end
            tick();
            if (k < 4) j++;
            checks++; if (wr_enable !== 1'b1 || W_addr !== 5'(k + 1) || W_data !== 32'h100 + k)
                begin errors++; $display("[TB] FAIL fill_write[%0d]: got wr=%b addr=%0d data=%h expected wr=1 addr=%0d data=%h", k, wr_enable, W_addr, W_data, k + 1, 32'h100 + k); end
            checks++; if (queue_count !== ((k < 4) ? 3'(k + 1) : 3'd4)) begin errors++; $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", k, queue_count, (k < 4) ? k + 1 : 4); end
        end
        checks++; if (pending_mask !== 32'h0000_3C00) begin errors++; $display("[TB] FAIL fill_mask: got %h expected 00003c00", pending_mask); end
        pipe_valid = 1'b0;
        for (int d = 0; d < 5; d++) begin
            if (d <= 1) begin
                checks++; if (late_ready !== (d == 1)) begin errors++; $display("[TB] FAIL drain_ready[%0d]: got %b expected %b", d, late_ready, (d == 1)); end
            end
            tick();
            if (d == 1) late_valid = 1'b0;
            checks++; if (wr_enable !== 1'b1 || W_addr !== 5'(10 + d) || W_data !== 32'h500 + d)
                begin errors++; $display("[TB] FAIL drain_write[%0d]: got wr=%b addr=%0d data=%h expected wr=1 addr=%0d data=%h", d, wr_enable, W_addr, W_data, 10 + d, 32'h500 + d); end
            checks++; if (queue_count !== expCount[d]) begin errors++; $display("[TB] FAIL drain_count[%0d]: got %0d expected %0d", d, queue_count, expCount[d]); end
            if (d == 1) begin
                checks++; if (pending_mask !== 32'h0000_7000) begin errors++; $display("[TB] FAIL drain_mask: got %h expected 00007000", pending_mask); end
            end
        end
        idleInputs();
        tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("[TB] FAIL drain_done_wr: got %b expected 0", wr_enable); end
    endtask

    task automatic test_waw_squash();
        pipe_valid = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h20;
        late_valid = 1'b1; late_addr = 5'd3; late_data = 32'h33;
        tick();
        pipe_addr = 5'd21; pipe_data = 32'h21;
        late_addr = 5'd7; late_data = 32'h11;
        tick();
        checks++; if (pending_mask !== 32'h0000_0088) begin errors++; $display("[TB] FAIL waw_mask_before: got %h expected 00000088", pending_mask); end
        pipe_addr = 5'd7; pipe_data = 32'h22;
        late_valid = 1'b0;
        tick();
        pipe_valid = 1'b0;
        checks++; if (pending_mask !== 32'h0000_0008) begin errors++; $display("[TB] FAIL waw_mask_after: got %h expected 00000008", pending_mask); end
        checks++; if (queue_count !== 3'd1) begin errors++; $display("[TB] FAIL waw_count: got %0d expected 1", queue_count); end
        tick();
        checks++; if (wr_enable !== 1'b1 || W_addr !== 5'd3 || W_data !== 32'h33) begin errors++; $display("[TB] FAIL waw_pop_r3: got wr=%b addr=%0d data=%h expected wr=1 addr=3 data=33", wr_enable, W_addr, W_data); end
        late_valid = 1'b1; late_addr = 5'd4; late_data = 32'h44;
        checks++; if (late_ready !== 1'b1) begin errors++; $display("[TB] FAIL waw_late_ready: got %b expected 1", late_ready); end
        tick();
        late_valid = 1'b0;
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("[TB] FAIL waw_dead_pop: got wr=%b expected 0", wr_enable); end
        checks++; if (queue_count !== 3'd1) begin errors++; $display("[TB] FAIL waw_enqueued: got %0d expected 1", queue_count); end
        tick();
        checks++; if (wr_enable !== 1'b1 || W_addr !== 5'd4 || W_data !== 32'h44) begin errors++; $display("[TB] FAIL waw_pop_r4: got wr=%b addr=%0d data=%h expected wr=1 addr=4 data=44", wr_enable, W_addr, W_data); end
        idleInputs();
        tick();
        checks++; if (shadowRf[7] !== 32'h22) begin errors++; $display("[TB] FAIL waw_final_r7: got %h expected 22", shadowRf[7]); end
        checks++; if (saw11 !== 1'b0) begin errors++; $display("[TB] FAIL waw_stale_write: got %b expected 0", saw11); end
    endtask

    task automatic test_collision();
        pipe_valid = 1'b1; pipe_addr = 5'd9; pipe_data = 32'hAA;
        late_valid = 1'b1; late_addr = 5'd9; late_data = 32'hBB;
        checks++; if (late_ready !== 1'b1) begin errors++; $display("[TB] FAIL coll_ready: got %b expected 1", late_ready); end
        tick();
        idleInputs();
        checks++; if (wr_enable !== 1'b1 || W_addr !== 5'd9 || W_data !== 32'hAA) begin errors++; $display("[TB] FAIL coll_write: got wr=%b addr=%0d data=%h expected wr=1 addr=9 data=aa", wr_enable, W_addr, W_data); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("[TB] FAIL coll_count: got %0d expected 0", queue_count); end
        tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("[TB] FAIL coll_no_late: got wr=%b data=%h expected wr=0", wr_enable, W_data); end
    endtask

    task automatic test_reg0();
        pipe_valid = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h55;
        late_valid = 1'b1; late_addr = 5'd0; late_data = 32'h66;
        checks++; if (late_ready !== 1'b1) begin errors++; $display("[TB] FAIL reg0_ready: got %b expected 1", late_ready); end
        tick();
        idleInputs();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("[TB] FAIL reg0_wr: got %b expected 0", wr_enable); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("[TB] FAIL reg0_count: got %0d expected 0", queue_count); end
        tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("[TB] FAIL reg0_wr_late: got %b expected 0", wr_enable); end
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 3; k++) begin
            pipe_valid = 1'b1; pipe_addr = 5'(k + 1); pipe_data = 32'h900 + k;
            late_valid = 1'b1; late_addr = 5'(15 + k); late_data = 32'hA00 + k;
            tick();
        end
        checks++; if (queue_count !== 3'd3) begin errors++; $display("[TB] FAIL mid_count_before: got %0d expected 3", queue_count); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("[TB] FAIL mid_wr: got %b expected 0", wr_enable); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 0", queue_count); end
        checks++; if (pending_mask !== 32'd0) begin errors++; $display("[TB] FAIL mid_mask: got %h expected 0", pending_mask); end
        checks++; if (late_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_ready: got %b expected 0", late_ready); end
        idleInputs();
        tick();
        reset = 1'b1;
        #1;
        checks++; if (late_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_release_ready: got %b expected 1", late_ready); end
        tick();
        checks++; if (wr_enable !== 1'b0 || W_addr !== 5'd0) begin errors++; $display("[TB] FAIL mid_after: got wr=%b addr=%0d expected wr=0 addr=0", wr_enable, W_addr); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_fill_drain();
        test_waw_squash();
        test_collision();
        test_reg0();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
